// File: rtl/input_capture_fsm.sv
// Calculator front end: conditions ENTER (and UNDO when INPUT_FSM_UNDO_EN is defined)
// and steps operand A -> operand B -> operation -> result, pulsing one load per step.

module input_capture_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          stable_q, stablePrev_q;
  logic [CW-1:0] cnt_q;

  // Any cycle where the synchronized level agrees with stable restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stablePrev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stablePrev_q <= stable_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = stable_q & ~stablePrev_q;
endmodule

module input_capture_fsm #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_enter,
  input  logic       btn_undo,
  output logic       load_a,
  output logic       load_b,
  output logic       load_op,
  output logic       clear,
  output logic [1:0] state
);
  localparam logic [1:0] S_A   = 2'd0;
  localparam logic [1:0] S_B   = 2'd1;
  localparam logic [1:0] S_OP  = 2'd2;
  localparam logic [1:0] S_RES = 2'd3;

  logic       enterPress, undoPress;
  logic [1:0] state_q, state_d;
  logic       loadA_q, loadA_d, loadB_q, loadB_d;
  logic       loadOp_q, loadOp_d, clear_q, clear_d;

  input_capture_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uEnter (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_enter),
    .press_o(enterPress)
  );

`ifdef INPUT_FSM_UNDO_EN
  input_capture_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uUndo (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_undo),
    .press_o(undoPress)
  );
`else
  logic unusedUndo;
  assign unusedUndo = btn_undo;
  assign undoPress  = 1'b0;
`endif

  // ENTER has priority; an UNDO press landing in the same cycle is dropped.
  always_comb begin
    state_d  = state_q;
    loadA_d  = 1'b0;
    loadB_d  = 1'b0;
    loadOp_d = 1'b0;
    clear_d  = 1'b0;
    if (enterPress) begin
      case (state_q)
        S_A:     begin state_d = S_B;   loadA_d  = 1'b1; end
        S_B:     begin state_d = S_OP;  loadB_d  = 1'b1; end
        S_OP:    begin state_d = S_RES; loadOp_d = 1'b1; end
        default: begin state_d = S_A;   clear_d  = 1'b1; end
      endcase
    end else if (undoPress) begin
      case (state_q)
        S_B:     state_d = S_A;
        S_OP:    state_d = S_B;
        S_RES:   state_d = S_OP;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_A;
      loadA_q  <= 1'b0;
      loadB_q  <= 1'b0;
      loadOp_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      loadA_q  <= loadA_d;
      loadB_q  <= loadB_d;
      loadOp_q <= loadOp_d;
      clear_q  <= clear_d;
    end
  end

  assign state   = state_q;
  assign load_a  = loadA_q;
  assign load_b  = loadB_q;
  assign load_op = loadOp_q;
  assign clear   = clear_q;
endmodule

// File: tb/tb_input_capture_fsm.sv
// Scoreboard bench for input_capture_fsm: expected pulses are queued when a press
// is driven and matched against pulses observed on the falling clock edge.

module tb_input_capture_fsm;
  localparam int DEB = 4;
`ifdef INPUT_FSM_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btnEnter = 1'b0;
  logic       btnUndo = 1'b0;
  logic       loadA, loadB, loadOp, clear;
  logic [1:0] state;

  typedef struct {
    logic [3:0] pulses;
    logic [1:0] state;
    int         cycle;
  } exp_t;

  exp_t       sbQ[$];
  int         compared = 0;
  int         mismatched = 0;
  int         cycle = 0;
  logic [1:0] modelState = 2'd0;
  logic [3:0] monPulses;
  exp_t       monExp;

  input_capture_fsm #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_enter(btnEnter),
    .btn_undo (btnUndo),
    .load_a   (loadA),
    .load_b   (loadB),
    .load_op  (loadOp),
    .clear    (clear),
    .state    (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Every pulse seen must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      monPulses = {clear, loadOp, loadB, loadA};
      if (monPulses != 4'b0000) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedPulse", 32'(monPulses), 32'd0);
        end else begin
          monExp = sbQ.pop_front();
          checkOutput("pulse", 32'(monPulses), 32'(monExp.pulses));
          checkOutput("stateWithPulse", 32'(state), 32'(monExp.state));
          if (monExp.cycle >= 0) checkOutput("pulseCycle", cycle, monExp.cycle);
        end
      end
    end
  end

  // Drives ENTER and/or UNDO for holdCycles, then releases and lets things settle.
  task automatic applyStimulus(input logic enter, input logic undo,
                               input int holdCycles, input bit timed);
    exp_t e;
    @(negedge clk);
    if (enter) begin
      e.pulses = 4'b0001 << modelState;
      e.state  = modelState + 2'd1;
      e.cycle  = timed ? cycle + DEB + 3 : -1;
      sbQ.push_back(e);
      modelState = modelState + 2'd1;
    end else if (undo && UNDO_EN && modelState != 2'd0) begin
      modelState = modelState - 2'd1;
    end
    btnEnter = enter;
    btnUndo  = undo;
    repeat (holdCycles) @(negedge clk);
    btnEnter = 1'b0;
    btnUndo  = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("stateAfterPress", 32'(state), 32'(modelState));
    checkOutput("scoreboardDrained", sbQ.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("resetState", 32'(state), 32'd0);
    checkOutput("resetPulses", 32'({clear, loadOp, loadB, loadA}), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Bounce: two 3-cycle bursts never reach the debounce threshold.
    btnEnter = 1'b1;
    repeat (3) @(negedge clk);
    btnEnter = 1'b0;
    @(negedge clk);
    btnEnter = 1'b1;
    repeat (3) @(negedge clk);
    btnEnter = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("bounceState", 32'(state), 32'd0);
    checkOutput("bounceDrained", sbQ.size(), 32'd0);

    applyStimulus(1'b1, 1'b0, 12, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 12, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 12, 1'b0);
    applyStimulus(1'b1, 1'b0, 200, 1'b0);
    applyStimulus(1'b1, 1'b0, 12, 1'b0);
    applyStimulus(1'b0, 1'b1, 12, 1'b0);
    applyStimulus(1'b1, 1'b1, 12, 1'b0);
    for (int i = 0; i < 4 && modelState != 2'd0; i++) applyStimulus(1'b1, 1'b0, 12, 1'b0);
    applyStimulus(1'b0, 1'b1, 12, 1'b0);

    for (int i = 0; i < 4 && modelState != 2'd2; i++) applyStimulus(1'b1, 1'b0, 12, 1'b0);
    checkOutput("reachedOp", 32'(state), 32'd2);
    @(negedge clk);
    btnEnter = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("asyncResetState", 32'(state), 32'd0);
    checkOutput("asyncResetPulses", 32'({clear, loadOp, loadB, loadA}), 32'd0);
    modelState = 2'd0;
    @(posedge clk);
    #2 btnEnter = 1'b0;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("postResetState", 32'(state), 32'd0);
    checkOutput("postResetDrained", sbQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
